smart_home_status_tx: RTL and testbench

- Serial status transmitter for the Smart_Home controller.
- Snapshots the controller outputs (heating, cooling, blinders state, light colour) and the current temperature, and sends them as a 2-byte UART-style frame to the wall display panel.
- Sits downstream of Smart_Home. It is the outbound-reporting end of the controller's sensor/actuator interface.
- A frame is sent automatically whenever any reported value changes, or on an explicit request.

---
 rtl/smart_home_status_tx.sv | 211 +++++++++++++++++++++
 tb/tb_smart_home_status_tx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/smart_home_status_tx.sv
// ============================================================================
// smart_home_status_tx
// ----------------------------------------------------------------------------
// Serial status transmitter for the Smart_Home controller. It snapshots the
// controller outputs (heating, cooling, blinders state, light colour) and the
// current temperature, then sends them to the wall display panel as a 2-byte
// UART-style frame. A frame goes out automatically whenever any reported value
// differs from the last one sent, or when send_req is pulsed while idle.
//
// Frame layout (each byte: start bit 0, 8 data bits LSB first, stop bit 1):
//    byte0 = {START_MARKER, heating, cooling, out[1:0], colour[2:0]}
//    byte1 = {3'b000, temperature[4:0]}
// byte1's start bit follows byte0's stop bit directly.
//
// Optional feature macro: STATUS_TX_PARITY_EN
//    When defined, an even-parity bit (XOR of the 8 data bits) is inserted
//    between data bit 7 and the stop bit of each byte (11-bit bytes).
//
// Parameters:
//    CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//    START_MARKER  bit 7 of byte0, lets the panel identify the first byte
//
// Ports:
//    clk          system clock, rising edge
//    rst          asynchronous active-high reset
//    heating      heating actuator state
//    cooling      cooling actuator state
//    out[1:0]     blinders state
//    colour[2:0]  light colour index
//    temperature  current temperature, unsigned 5 bits
//    send_req     single-cycle request to force a frame (ignored while busy)
//    tx           serial line, idles high
//    busy         high while a frame is in flight
//    frame_done   one-cycle pulse after the final stop bit completes
// ============================================================================
module smart_home_status_tx #(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter logic        START_MARKER = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       heating,
   input  logic       cooling,
   input  logic [1:0] out,
   input  logic [2:0] colour,
   input  logic [4:0] temperature,
   input  logic       send_req,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

   // Last baud count value of a bit period; a bit ends on the edge where the
   // counter sits at this value.
   localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

   // Transmit states. The completion of byte1's stop bit returns straight to
   // IDLE with frame_done raised, so no separate DONE state is held.
`ifdef STATUS_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3
   } state_t;
`endif

   state_t      state;
   state_t      state_next;
   logic [15:0] baud_cnt;
   logic [15:0] baud_cnt_next;
   logic [2:0]  bit_cnt;
   logic [2:0]  bit_cnt_next;
   logic        byte_idx;
   logic        byte_idx_next;
   logic [15:0] frame_data;
   logic [15:0] frame_data_next;
   logic [9:0]  last_sent;
   logic [9:0]  last_sent_next;
   logic        tx_next;
   logic        busy_next;
   logic        frame_done_next;

   logic [9:0]  status;
   logic        trigger;
   logic [7:0]  cur_byte;
   logic        baud_end;

   // The status vector is compared against what was last transmitted; any
   // difference, or an explicit request, starts a frame when idle.
   always_comb begin
      status   = {heating, cooling, out, colour, temperature};
      trigger  = (status != last_sent) || send_req;
      cur_byte = byte_idx ? frame_data[15:8] : frame_data[7:0];
      baud_end = (baud_cnt == BAUD_MAX);
   end

   // State and datapath registers. tx/busy/frame_done are registered so the
   // serial line is glitch-free and reset forces them immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         byte_idx   <= 1'b0;
         frame_data <= '0;
         last_sent  <= '0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         baud_cnt   <= baud_cnt_next;
         bit_cnt    <= bit_cnt_next;
         byte_idx   <= byte_idx_next;
         frame_data <= frame_data_next;
         last_sent  <= last_sent_next;
         tx         <= tx_next;
         busy       <= busy_next;
         frame_done <= frame_done_next;
      end
   end

   // Next-state logic. Each state holds its tx level for CLKS_PER_BIT cycles;
   // on the last cycle of a bit the next bit's level is loaded into tx_next so
   // the line changes exactly on the bit boundary edge.
   always_comb begin
      state_next      = state;
      baud_cnt_next   = baud_cnt;
      bit_cnt_next    = bit_cnt;
      byte_idx_next   = byte_idx;
      frame_data_next = frame_data;
      last_sent_next  = last_sent;
      tx_next         = tx;
      busy_next       = busy;
      frame_done_next = 1'b0;

      if (state == IDLE) begin
         tx_next   = 1'b1;
         busy_next = 1'b0;
         if (trigger) begin
            frame_data_next = {3'b000, temperature,
                               START_MARKER, heating, cooling, out, colour};
            last_sent_next  = status;
            busy_next       = 1'b1;
            tx_next         = 1'b0;
            baud_cnt_next   = '0;
            bit_cnt_next    = '0;
            byte_idx_next   = 1'b0;
            state_next      = START;
         end
      end else if (!baud_end) begin
         baud_cnt_next = baud_cnt + 16'd1;
      end else begin
         baud_cnt_next = '0;
         case (state)
            START: begin
               bit_cnt_next = '0;
               tx_next      = cur_byte[0];
               state_next   = DATA;
            end
            DATA: begin
               if (bit_cnt == 3'd7) begin
`ifdef STATUS_TX_PARITY_EN
                  tx_next    = ^cur_byte;
                  state_next = PARITY;
`else
                  tx_next    = 1'b1;
                  state_next = STOP;
`endif
               end else begin
                  bit_cnt_next = bit_cnt + 3'd1;
                  tx_next      = cur_byte[bit_cnt + 3'd1];
               end
            end
`ifdef STATUS_TX_PARITY_EN
            PARITY: begin
               tx_next    = 1'b1;
               state_next = STOP;
            end
`endif
            STOP: begin
               if (!byte_idx) begin
                  byte_idx_next = 1'b1;
                  tx_next       = 1'b0;
                  state_next    = START;
               end else begin
                  tx_next         = 1'b1;
                  busy_next       = 1'b0;
                  frame_done_next = 1'b1;
                  state_next      = IDLE;
               end
            end
            default: begin
               tx_next    = 1'b1;
               busy_next  = 1'b0;
               state_next = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_smart_home_status_tx.sv
// ============================================================================
// tb_smart_home_status_tx
// ----------------------------------------------------------------------------
// Directed self-checking bench for smart_home_status_tx with CLKS_PER_BIT=4.
// Inputs are driven on falling edges; tx is sampled mid-bit on falling edges
// and the captured bits are compared against hand-computed frame bytes.
// ============================================================================
module tb_smart_home_status_tx;

   localparam int CPB = 4;
`ifdef STATUS_TX_PARITY_EN
   localparam int BPB = 11;
`else
   localparam int BPB = 10;
`endif
   localparam int FRAME_CYC = 2 * BPB * CPB;

   logic       clk;
   logic       rst;
   logic       heating;
   logic       cooling;
   logic [1:0] out;
   logic [2:0] colour;
   logic [4:0] temperature;
   logic       send_req;
   logic       tx;
   logic       busy;
   logic       frame_done;

   int vector_count = 0;
   int miss_count   = 0;

   smart_home_status_tx #(
      .CLKS_PER_BIT (CPB),
      .START_MARKER (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .heating     (heating),
      .cooling     (cooling),
      .out         (out),
      .colour      (colour),
      .temperature (temperature),
      .send_req    (send_req),
      .tx          (tx),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vector_count++;
      if (observed !== expected) begin
         miss_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives a new input set on a falling edge; the following rising edge is
   // the candidate trigger edge.
   task automatic applyStimulus(input logic h, input logic c, input logic [1:0] o,
                                input logic [2:0] col, input logic [4:0] temp,
                                input logic req);
      @(negedge clk);
      heating     = h;
      cooling     = c;
      out         = o;
      colour      = col;
      temperature = temp;
      send_req    = req;
   endtask

   // Watches one frame assumed to trigger on the next rising edge. Optionally
   // changes temperature at falling edge chg_cyc and pulses send_req at
   // falling edge req_cyc (0 disables either). Ends on the falling edge right
   // after the completion edge, i.e. just before the next possible trigger.
   task automatic captureFrame(input string name, input logic [7:0] exp_b0,
                               input logic [7:0] exp_b1, input logic exp_p0,
                               input logic exp_p1, input int chg_cyc,
                               input logic [4:0] chg_temp, input int req_cyc);
      logic [21:0] bits;
      logic [7:0]  data;
      int          done_cnt;
      int          done_pos;
      int          busy_gap;
      int          base;
      bits     = '0;
      done_cnt = 0;
      done_pos = -1;
      busy_gap = 0;
      for (int j = 1; j <= FRAME_CYC + 1; j++) begin
         @(negedge clk);
         if (j == 1) send_req = 1'b0;
         if (j == chg_cyc) temperature = chg_temp;
         if (req_cyc > 0 && j == req_cyc) send_req = 1'b1;
         if (req_cyc > 0 && j == req_cyc + 1) send_req = 1'b0;
         if ((j % CPB) == (CPB / 2)) bits[(j - CPB / 2) / CPB] = tx;
         if (frame_done) begin
            done_cnt++;
            done_pos = j;
         end
         if (j <= FRAME_CYC && !busy) busy_gap++;
      end
      checkOutput({name, " busy_held"}, busy_gap, 0);
      checkOutput({name, " busy_end"}, busy, 0);
      checkOutput({name, " done_count"}, done_cnt, 1);
      checkOutput({name, " done_latency"}, done_pos - 1, FRAME_CYC);
      for (int b = 0; b < 2; b++) begin
         base = b * BPB;
         data = '0;
         for (int i = 0; i < 8; i++) data[i] = bits[base + 1 + i];
         checkOutput($sformatf("%s byte%0d_start", name, b), bits[base], 0);
         checkOutput($sformatf("%s byte%0d_data", name, b), data,
                     (b == 0) ? exp_b0 : exp_b1);
`ifdef STATUS_TX_PARITY_EN
         checkOutput($sformatf("%s byte%0d_parity", name, b), bits[base + 9],
                     (b == 0) ? exp_p0 : exp_p1);
`else
         if (exp_p0 || exp_p1) begin
         end
`endif
         checkOutput($sformatf("%s byte%0d_stop", name, b), bits[base + BPB - 1], 1);
      end
   endtask

   // Idle window: the line must stay high, busy low, and no frame_done.
   task automatic idleCheck(input string name, input int n);
      int busy_cnt;
      int low_cnt;
      int done_cnt;
      busy_cnt = 0;
      low_cnt  = 0;
      done_cnt = 0;
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (!tx) low_cnt++;
         if (frame_done) done_cnt++;
      end
      checkOutput({name, " idle_busy"}, busy_cnt, 0);
      checkOutput({name, " idle_tx_low"}, low_cnt, 0);
      checkOutput({name, " idle_done"}, done_cnt, 0);
   endtask

   initial begin
      rst         = 1'b1;
      heating     = 1'b0;
      cooling     = 1'b0;
      out         = 2'b00;
      colour      = 3'd0;
      temperature = 5'd0;
      send_req    = 1'b0;

      // Reset state with all inputs zero, then a long quiet idle.
      repeat (3) @(negedge clk);
      checkOutput("reset tx", tx, 1);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset frame_done", frame_done, 0);
      rst = 1'b0;
      idleCheck("post_reset", 100);

      // Status change triggers a frame: byte0 0xDB, byte1 0x12 (18).
      applyStimulus(1'b1, 1'b0, 2'b11, 3'd3, 5'd18, 1'b0);
      captureFrame("change", 8'hDB, 8'h12, 1'b0, 1'b0, 0, 5'd0, 0);

      // send_req with S unchanged sends an identical frame; temperature
      // moves to 19 mid-frame but the bits in flight keep 0x12.
      applyStimulus(1'b1, 1'b0, 2'b11, 3'd3, 5'd18, 1'b1);
      captureFrame("request", 8'hDB, 8'h12, 1'b0, 1'b0, 30, 5'd19, 0);

      // The pending change re-triggers on the very next edge; a send_req
      // pulse while busy must not add another frame afterwards.
      captureFrame("followup", 8'hDB, 8'h13, 1'b0, 1'b1, 0, 5'd0, 45);
      idleCheck("no_extra", 40);

      // Reset asserted mid-frame takes effect before any clock edge.
      applyStimulus(1'b1, 1'b0, 2'b11, 3'd3, 5'd19, 1'b1);
      for (int j = 1; j < 45; j++) begin
         @(negedge clk);
         if (j == 1) send_req = 1'b0;
      end
      @(negedge clk);
      checkOutput("pre_reset busy", busy, 1);
      rst = 1'b1;
      #1;
      checkOutput("async_reset tx", tx, 1);
      checkOutput("async_reset busy", busy, 0);
      checkOutput("async_reset frame_done", frame_done, 0);
      repeat (3) @(negedge clk);
      checkOutput("held_reset tx", tx, 1);
      checkOutput("held_reset busy", busy, 0);
      rst = 1'b0;
      captureFrame("after_reset", 8'hDB, 8'h13, 1'b0, 1'b1, 0, 5'd0, 0);

      // Illegal colour is sent unmodified: byte0 0x87, byte1 0x00.
      applyStimulus(1'b0, 1'b0, 2'b00, 3'd7, 5'd0, 1'b0);
      captureFrame("colour7", 8'h87, 8'h00, 1'b0, 1'b0, 0, 5'd0, 0);
      idleCheck("final", 20);

      $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
      $finish;
   end

endmodule
